// File: rtl/note_player.sv
// Single-voice square-wave note player: pitch timed on clk, duration/gap timed in ms_clk ticks.
// Optional `define OCTAVE_EN adds note_oct[1:0], which shifts the half-period right (octave 4..7).
module note_player #(
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned DUR_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_clk,
  input  logic [3:0]       note_code,
  input  logic [DUR_W-1:0] note_dur,
`ifdef OCTAVE_EN
  input  logic [1:0]       note_oct,
`endif
  input  logic             note_valid,
  output logic             note_ready,
  output logic             spk,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  localparam logic [DUR_W-1:0] GapLoad = DUR_W'(GAP_TICKS);
  localparam logic [DUR_W-1:0] DurOne  = DUR_W'(1);

  state_e           state_q, state_d;
  logic             ms_clk_q, ms_clk_d;
  logic             rest_q, rest_d;
  logic [16:0]      hp_q, hp_d;
  logic [16:0]      pcnt_q, pcnt_d;
  logic [DUR_W-1:0] dcnt_q, dcnt_d;
  logic             spk_q, spk_d;

  logic             tick;
  logic [16:0]      tab_hp;
  logic [16:0]      note_hp;

  // ms_clk is generated from clk, so a plain edge detector is enough.
  assign tick = ms_clk & ~ms_clk_q;

  always_comb begin
    tab_hp = 17'd0;
    case (note_code)
      4'd0:    tab_hp = 17'd95556;
      4'd1:    tab_hp = 17'd90193;
      4'd2:    tab_hp = 17'd85131;
      4'd3:    tab_hp = 17'd80353;
      4'd4:    tab_hp = 17'd75843;
      4'd5:    tab_hp = 17'd71586;
      4'd6:    tab_hp = 17'd67568;
      4'd7:    tab_hp = 17'd63776;
      4'd8:    tab_hp = 17'd60196;
      4'd9:    tab_hp = 17'd56818;
      4'd10:   tab_hp = 17'd53629;
      4'd11:   tab_hp = 17'd50619;
      default: tab_hp = 17'd0;
    endcase
  end

`ifdef OCTAVE_EN
  assign note_hp = tab_hp >> note_oct;
`else
  assign note_hp = tab_hp;
`endif

  always_comb begin
    state_d  = state_q;
    ms_clk_d = ms_clk;
    rest_d   = rest_q;
    hp_d     = hp_q;
    pcnt_d   = pcnt_q;
    dcnt_d   = dcnt_q;
    spk_d    = spk_q;

    if (rst) begin
      state_d  = StIdle;
      ms_clk_d = 1'b0;
      rest_d   = 1'b0;
      hp_d     = 17'd0;
      pcnt_d   = 17'd0;
      dcnt_d   = '0;
      spk_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          spk_d = 1'b0;
          if (note_valid) begin
            rest_d = (note_code[3:2] == 2'b11);
            hp_d   = note_hp;
            pcnt_d = 17'd0;
            if (note_dur == '0) begin
              state_d = StGap;
              dcnt_d  = GapLoad;
            end else begin
              state_d = StPlay;
              dcnt_d  = note_dur;
            end
          end
        end
        StPlay: begin
          if (!rest_q) begin
            if (pcnt_q == hp_q - 17'd1) begin
              spk_d  = ~spk_q;
              pcnt_d = 17'd0;
            end else begin
              pcnt_d = pcnt_q + 17'd1;
            end
          end
          // The final tick overrides any pitch toggle in the same cycle.
          if (tick) begin
            if (dcnt_q == DurOne) begin
              state_d = StGap;
              dcnt_d  = GapLoad;
              spk_d   = 1'b0;
              pcnt_d  = 17'd0;
            end else begin
              dcnt_d = dcnt_q - DurOne;
            end
          end
        end
        StGap: begin
          spk_d = 1'b0;
          if (dcnt_q == '0) begin
            state_d = StIdle;
          end else if (tick) begin
            dcnt_d = dcnt_q - DurOne;
            if (dcnt_q == DurOne) state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          spk_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    ms_clk_q <= ms_clk_d;
    rest_q   <= rest_d;
    hp_q     <= hp_d;
    pcnt_q   <= pcnt_d;
    dcnt_q   <= dcnt_d;
    spk_q    <= spk_d;
  end

  assign spk        = spk_q;
  assign busy       = (state_q != StIdle);
  assign note_ready = (state_q == StIdle);

endmodule
